// File: rtl/sector_buffer.sv
// Multi-bank sector buffer: producer streams whole sectors in, consumer reads the oldest one.
// Optional head-bank checksum is enabled by defining SECTOR_BUFFER_CHKSUM_EN.
module sector_buffer #(
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned DATA_W       = 8,
  localparam int unsigned AW          = $clog2(SECTOR_BYTES),
  localparam int unsigned BW          = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              wr_abort,
  output logic              wr_overflow,
  output logic              rd_avail,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release,
  output logic [BW:0]       bank_count,
  output logic [15:0]       rd_chksum
);

  localparam int unsigned DEPTH = NUM_BANKS * SECTOR_BYTES;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [BW-1:0] wbank_q, wbank_d;
  logic [BW-1:0] rbank_q, rbank_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [BW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic accept, last_byte, commit, release_ok;

  assign wr_ready    = (count_q != (BW+1)'(NUM_BANKS));
  assign rd_avail    = (count_q != '0);
  assign bank_count  = count_q;
  assign wr_overflow = ovf_q;

  // Abort wins over a byte presented in the same cycle.
  assign accept     = wr_valid && wr_ready && !wr_abort;
  assign last_byte  = (wcnt_q == AW'(SECTOR_BYTES - 1));
  assign commit     = accept && last_byte;
  assign release_ok = rd_release && rd_avail;

  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wbank_d = '0;
      rbank_d = '0;
      wcnt_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_abort) begin
        wcnt_d = '0;
      end else if (accept) begin
        wcnt_d = last_byte ? '0 : wcnt_q + AW'(1);
      end
      if (commit) begin
        wbank_d = wbank_q + BW'(1);
      end
      if (release_ok) begin
        rbank_d = rbank_q + BW'(1);
      end
      unique case ({commit, release_ok})
        2'b10:   count_d = count_q + (BW+1)'(1);
        2'b01:   count_d = count_q - (BW+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr_valid && !wr_ready) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbank_q <= '0;
      rbank_q <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM array itself has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && !flush && accept) begin
      mem[{wbank_q, wcnt_q}] <= wr_data;
    end
  end

  // Flush freezes rd_data for one cycle; it keeps the last value read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (!flush) begin
      rd_data <= mem[{rbank_q, rd_addr}];
    end
  end

`ifdef SECTOR_BUFFER_CHKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] sum_inc;
  logic [15:0] chk_q [NUM_BANKS];

  assign sum_inc = sum_q + 16'(wr_data);

  always_comb begin
    sum_d = sum_q;
    if (flush || wr_abort) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = last_byte ? '0 : sum_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        chk_q[i] <= '0;
      end
    end else begin
      sum_q <= sum_d;
      if (!flush && commit) begin
        chk_q[wbank_q] <= sum_inc;
      end
    end
  end

  assign rd_chksum = chk_q[rbank_q];
`else
  assign rd_chksum = '0;
`endif

endmodule

// File: tb/tb_sector_buffer.sv
// Directed self-checking bench for sector_buffer (2 banks x 512 bytes x 8 bits).
// Checksum expectations follow SECTOR_BUFFER_CHKSUM_EN.
module tb_sector_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, wr_valid, wr_abort, rd_release;
  logic [7:0]  wr_data;
  logic [8:0]  rd_addr;
  logic        wr_ready, wr_overflow, rd_avail;
  logic [7:0]  rd_data;
  logic [1:0]  bank_count;
  logic [15:0] rd_chksum;

  int total = 0;
  int bad   = 0;
  logic [15:0] sum_model;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t t1_vec [6];
  rd_vec_t t4_vec [4];

  sector_buffer #(
    .NUM_BANKS    (2),
    .SECTOR_BYTES (512),
    .DATA_W       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_abort    (wr_abort),
    .wr_overflow (wr_overflow),
    .rd_avail    (rd_avail),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_release  (rd_release),
    .bank_count  (bank_count),
    .rd_chksum   (rd_chksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_sum(input string name, input logic [15:0] exp);
`ifdef SECTOR_BUFFER_CHKSUM_EN
    check(name, 32'(rd_chksum), 32'(exp));
`else
    check(name, 32'(rd_chksum), 32'h0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_abort = 1'b0;
    rd_release = 1'b0; wr_data = '0; rd_addr = '0;
    cycle();
    cycle();
    reset = 1'b0;
    sum_model = '0;
  endtask

  task automatic write_bytes(input int n, input int start, input int step);
    for (int i = 0; i < n; i++) begin
      wr_valid  = 1'b1;
      wr_data   = 8'(start + i * step);
      sum_model = sum_model + 16'(wr_data);
      cycle();
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_at(input string name, input logic [8:0] a, input logic [7:0] exp);
    rd_addr = a;
    cycle();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic release_head();
    rd_release = 1'b1;
    cycle();
    rd_release = 1'b0;
  endtask

  initial begin
    t1_vec[0] = '{9'h000, 8'h00};
    t1_vec[1] = '{9'h001, 8'h01};
    t1_vec[2] = '{9'h07F, 8'h7F};
    t1_vec[3] = '{9'h100, 8'h00};
    t1_vec[4] = '{9'h1A5, 8'hA5};
    t1_vec[5] = '{9'h1FF, 8'hFF};
    // Sector after abort: byte i = (7 + 3*i) mod 256.
    t4_vec[0] = '{9'h000, 8'h07};
    t4_vec[1] = '{9'h001, 8'h0A};
    t4_vec[2] = '{9'h064, 8'h33};
    t4_vec[3] = '{9'h1FF, 8'h04};

    // 1: reset state, single sector, table-driven reads
    do_reset();
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_rd_avail", 32'(rd_avail), 0);
    check("rst_count", 32'(bank_count), 0);
    check("rst_ovf", 32'(wr_overflow), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    chk_sum("rst_chksum", 16'h0000);
    write_bytes(511, 0, 1);
    check("t1_avail_before_last", 32'(rd_avail), 0);
    write_bytes(1, 511, 1);
    check("t1_avail_after_last", 32'(rd_avail), 1);
    check("t1_count", 32'(bank_count), 1);
    check("t1_wr_ready", 32'(wr_ready), 1);
    for (int i = 0; i < 6; i++) begin
      read_at($sformatf("t1_rd[%0d]", i), t1_vec[i].addr, t1_vec[i].exp);
    end
    chk_sum("t1_chksum", 16'hFF00);

    // 2: fill to capacity, then overflow
    do_reset();
    write_bytes(1023, 0, 1);
    check("t2_ready_before_full", 32'(wr_ready), 1);
    write_bytes(1, 1023, 1);
    check("t2_ready_full", 32'(wr_ready), 0);
    check("t2_count_full", 32'(bank_count), 2);
    check("t2_ovf_clear", 32'(wr_overflow), 0);
    write_bytes(4, 8'h80, 1);
    check("t2_ovf_set", 32'(wr_overflow), 1);
    check("t2_count_still", 32'(bank_count), 2);
    read_at("t2_head_intact", 9'h002, 8'h02);

    // 3: two held sectors, release order, release-when-empty ignored
    do_reset();
    write_bytes(512, 8'hAA, 0);
    write_bytes(512, 8'h55, 0);
    read_at("t3_head_a", 9'h005, 8'hAA);
    chk_sum("t3_chksum_a", 16'h5400);
    release_head();
    check("t3_count_1", 32'(bank_count), 1);
    read_at("t3_head_b0", 9'h010, 8'h55);
    read_at("t3_head_b1", 9'h1FF, 8'h55);
    chk_sum("t3_chksum_b", 16'hAA00);
    release_head();
    check("t3_avail_0", 32'(rd_avail), 0);
    check("t3_count_0", 32'(bank_count), 0);
    release_head();
    check("t3_empty_release", 32'(bank_count), 0);
    write_bytes(512, 8'h33, 0);
    read_at("t3_rbank_held", 9'h007, 8'h33);

    // 4: abort mid-sector, abort wins over concurrent byte
    do_reset();
    write_bytes(100, 8'h11, 0);
    wr_valid = 1'b1; wr_abort = 1'b1; wr_data = 8'hEE;
    cycle();
    wr_valid = 1'b0; wr_abort = 1'b0;
    check("t4_count", 32'(bank_count), 0);
    sum_model = '0;
    write_bytes(511, 7, 3);
    check("t4_avail_before_last", 32'(rd_avail), 0);
    write_bytes(1, 7 + 511 * 3, 3);
    check("t4_avail", 32'(rd_avail), 1);
    for (int i = 0; i < 4; i++) begin
      read_at($sformatf("t4_rd[%0d]", i), t4_vec[i].addr, t4_vec[i].exp);
    end
    chk_sum("t4_chksum", sum_model);

    // 5: commit and release in the same cycle
    do_reset();
    write_bytes(512, 1, 0);
    check("t5_count_1", 32'(bank_count), 1);
    write_bytes(511, 2, 0);
    wr_valid = 1'b1; wr_data = 8'h02; rd_release = 1'b1;
    cycle();
    wr_valid = 1'b0; rd_release = 1'b0;
    check("t5_count_same", 32'(bank_count), 1);
    check("t5_avail", 32'(rd_avail), 1);
    read_at("t5_rbank_adv", 9'h003, 8'h02);

    // 6: flush from full with overflow, then flush mid-sector
    do_reset();
    write_bytes(1025, 8'h40, 0);
    check("t6_ovf_pre", 32'(wr_overflow), 1);
    flush = 1'b1; wr_valid = 1'b1;
    cycle();
    flush = 1'b0; wr_valid = 1'b0;
    check("t6_count", 32'(bank_count), 0);
    check("t6_avail", 32'(rd_avail), 0);
    check("t6_ovf", 32'(wr_overflow), 0);
    check("t6_ready", 32'(wr_ready), 1);
    write_bytes(10, 8'h99, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    sum_model = '0;
    write_bytes(512, 8'h20, 1);
    check("t6_avail_new", 32'(rd_avail), 1);
    check("t6_count_new", 32'(bank_count), 1);
    read_at("t6_rd0", 9'h000, 8'h20);
    read_at("t6_rd9", 9'h009, 8'h29);
    chk_sum("t6_chksum", sum_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
